// File: rtl/adder_pipe.sv
// adder_pipe: pipelined unsigned adder, one CHUNK-bit carry segment per stage,
// with valid/ready handshakes on both sides and a global stall.
//
// Parameters:
//   WIDTH   operand width (>=1, divisible by STAGES)
//   STAGES  pipeline depth / number of carry chunks (>=1)
// Ports:
//   clk, rst           rising-edge clock, async active-high reset
//   in_valid/in_ready  operand handshake (in_ready depends only on output side)
//   a, b               unsigned operands
//   sub                subtract select (only with ADDER_PIPE_SUB_EN)
//   out_valid/out_ready result handshake
//   sum                WIDTH+1 result, MSB is carry-out (add) or borrow (sub)
// Optional feature macro: ADDER_PIPE_SUB_EN enables the sub port.
module adder_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int unsigned CHUNK = (STAGES == 0) ? 1 : WIDTH / STAGES;

  // Reject illegal configurations at elaboration.
  if (STAGES == 0) begin : g_bad_stages
    $error("adder_pipe: STAGES must be >= 1");
  end else if ((WIDTH == 0) || ((WIDTH % STAGES) != 0)) begin : g_bad_width
    $error("adder_pipe: WIDTH must be >= 1 and divisible by STAGES");
  end

  // Global stall: everything moves only when the output slot is free or draining.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic sub_in;
`ifdef ADDER_PIPE_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Registered state of this stage
    logic             v_q, c_q, s_q;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    // Values arriving from the previous stage (or the input port)
    logic             v_d, c_d, s_d;
    logic [WIDTH-1:0] a_d, b_d, r_d;
    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] r_n;
    logic             c_n;

    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1: invert b once here, seed carry with sub.
      assign v_d = in_valid;
      assign a_d = a;
      assign b_d = b ^ {WIDTH{sub_in}};
      assign r_d = '0;
      assign c_d = sub_in;
      assign s_d = sub_in;
    end else begin : g_next
      assign v_d = g_stg[k-1].v_q;
      assign a_d = g_stg[k-1].a_q;
      assign b_d = g_stg[k-1].b_q;
      assign r_d = g_stg[k-1].r_q;
      assign c_d = g_stg[k-1].c_q;
      assign s_d = g_stg[k-1].s_q;
    end

    // Chunk adder for this stage
    assign part = (CHUNK+1)'(a_d[k*CHUNK +: CHUNK])
                + (CHUNK+1)'(b_d[k*CHUNK +: CHUNK])
                + (CHUNK+1)'(c_d);

    // Merge the new chunk into the partial result travelling with the entry
    always_comb begin
      r_n = r_d;
      r_n[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
    end

    // Last stage stores borrow (inverted carry) for subtracts so sum is a pure register.
    if (k == STAGES - 1) begin : g_last_carry
      assign c_n = part[CHUNK] ^ s_d;
    end else begin : g_mid_carry
      assign c_n = part[CHUNK];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        r_q <= '0;
      end else if (advance) begin
        v_q <= v_d;
        c_q <= c_n;
        s_q <= s_d;
        a_q <= a_d;
        b_q <= b_d;
        r_q <= r_n;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = {g_stg[STAGES-1].c_q, g_stg[STAGES-1].r_q};

  // Operand copies and mode bit in the final stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{g_stg[STAGES-1].a_q, g_stg[STAGES-1].b_q, g_stg[STAGES-1].s_q};

endmodule

// File: tb/tb_adder_pipe.sv
// Testbench for adder_pipe: directed vector table, backpressure, reset
// mid-stream, full-throughput burst and randomized handshake traffic checked
// against an arithmetic reference model and an in-order scoreboard.
module tb_adder_pipe;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;
`ifdef ADDER_PIPE_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, sub_tb;
  logic [W-1:0] a, b;
  logic [W:0]   sum;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
`ifdef ADDER_PIPE_SUB_EN
    .sub(sub_tb),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W:0]   exp;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  int         n_out    = 0;
  logic [W:0] exp_q[$];

  // Reference: plain arithmetic modulo 2^(W+1)
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    int unsigned xv, yv, m;
    xv = int'(x);
    yv = int'(y);
    m  = 1 << (W + 1);
    if (s) return (W+1)'((xv + m - yv) % m);
    return (W+1)'(xv + yv);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: decide transfers at negedge, they complete on the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub_tb));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0d expected none", sum);
        end else begin
          check("stream_sum", 32'(sum), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Called and returns at posedge+1; holds the pair until it is accepted.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    a = x;
    b = y;
    sub_tb = s;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  vec_t vecs[$];
  int   n, base;
  bit   bp_done, took;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sub_tb = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;

    // Directed vectors, one at a time: latency and value
    vecs.push_back('{a: 8'h0F, b: 8'h01, s: 1'b0, exp: 9'h010});
    vecs.push_back('{a: 8'hFF, b: 8'hFF, s: 1'b0, exp: 9'h1FE});
    vecs.push_back('{a: 8'h00, b: 8'h00, s: 1'b0, exp: 9'h000});
    vecs.push_back('{a: 8'd200, b: 8'd100, s: 1'b0, exp: 9'd300});
    vecs.push_back('{a: 8'h80, b: 8'h80, s: 1'b0, exp: 9'h100});
    vecs.push_back('{a: 8'hAA, b: 8'h55, s: 1'b0, exp: 9'h0FF});
    if (SUB) begin
      vecs.push_back('{a: 8'd3, b: 8'd5, s: 1'b1, exp: 9'h1FE});
      vecs.push_back('{a: 8'd9, b: 8'd4, s: 1'b1, exp: 9'd5});
      vecs.push_back('{a: 8'hFF, b: 8'hFF, s: 1'b1, exp: 9'd0});
      vecs.push_back('{a: 8'h00, b: 8'hFF, s: 1'b1, exp: 9'h101});
    end
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_out(n);
      check("vec_latency", 32'(n), 32'(S));
      check("vec_sum", 32'(sum), 32'(vecs[i].exp));
      @(posedge clk);
      #1;
    end

    // Backpressure: three pairs, output held off for 5 cycles
    base = n_out;
    out_ready = 1'b0;
    bp_done = 1'b0;
    fork
      begin
        send(8'd1, 8'd2, 1'b0);
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b0);
        bp_done = 1'b1;
      end
    join_none
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_sum_hold", 32'(sum), 32'(3));
      check("bp_in_ready", 32'(in_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    while (!bp_done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_done", 32'(bp_done), 32'(1));
    repeat (S + 2) @(posedge clk);
    #1;
    check("bp_count", 32'(n_out - base), 32'(3));

    // Reset with two transactions in flight
    in_valid = 1'b1;
    a = 8'd7;
    b = 8'd8;
    sub_tb = 1'b0;
    @(posedge clk);
    #1;
    a = 8'd9;
    b = 8'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_sum", 32'(sum), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = n_out;
    send(8'd10, 8'd20, 1'b0);
    wait_out(n);
    check("post_rst_sum", 32'(sum), 32'(30));
    repeat (S + 3) @(posedge clk);
    #1;
    check("post_rst_count", 32'(n_out - base), 32'(1));

    // Full-throughput burst
    base = n_out;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      sub_tb = SUB ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (!in_ready) n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (S) @(negedge clk);
    #1;
    check("burst_stalls", 32'(n), 32'(0));
    check("burst_throughput", 32'(n_out - base), 32'(64));

    // Random valid/ready traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
        b = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
        sub_tb = SUB ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    check("drain_out_valid", 32'(out_valid), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
